// File: rtl/axi_lite_regfile_bridge.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile_bridge
//
// AXI4-Lite slave that turns host accesses into single-cycle read/write
// strobes on the dmawr register file. Only one access is in flight at a
// time. A read that gets no reg_readdatavalid within TIMEOUT_CYCLES is
// answered with TIMEOUT_DATA / SLVERR, so the bus can never hang.
//
// Ports
//   sysclk, sysrst_n          clock, asynchronous active-low reset
//   s_axi_aw*                 write address channel (awaddr[1:0] ignored)
//   s_axi_w*                  write data channel (wdata, wstrb)
//   s_axi_b*                  write response, bresp always OKAY
//   s_axi_ar*                 read address channel (araddr[1:0] ignored)
//   s_axi_r*                  read data, rresp OKAY or SLVERR on timeout
//   reg_read / reg_write      one-cycle strobes towards the register file
//   reg_addr                  word address, held until the next access
//   reg_beN                   active-low byte enables (~wstrb)
//   reg_writedata             write data, valid with reg_write
//   reg_readdata/_valid       read return from the register file
// ---------------------------------------------------------------------------
module axi_lite_regfile_bridge #(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  sysclk,
  input  logic                  sysrst_n,
  // write address
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  // write data
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  // write response
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  // read address
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  // read data
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  // register file side
  output logic                  reg_read,
  output logic                  reg_write,
  output logic [ADDR_WIDTH-3:0] reg_addr,
  output logic [3:0]            reg_beN,
  output logic [31:0]           reg_writedata,
  input  logic [31:0]           reg_readdata,
  input  logic                  reg_readdatavalid
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_BRESP,
    S_RD,
    S_RWAIT,
    S_RRESP
  } state_t;

  state_t r_state, w_next;

  // r_active holds the readies low while reset is asserted and for the
  // first edge after release, so no handshake is offered from reset.
  logic                  r_active;

  // Independent AW / W holding registers
  logic                  r_aw_full;
  logic [ADDR_WIDTH-3:0] r_awaddr;
  logic                  r_w_full;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;

  // Round-robin pointer: 1 = the last contested grant went to a read.
  logic                  r_last_rd;

  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-3:0] r_reg_addr;
  logic [3:0]            r_reg_beN;
  logic [31:0]           r_reg_wdata;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;

  logic w_idle;
  logic w_awready;
  logic w_wready;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_pend;
  logic w_wr_ready;
  logic w_rd_grant;
  logic w_wr_go;
  logic w_conflict;
  logic w_to_hit;

  // Byte-offset bits of both addresses are intentionally dropped.
  logic w_unused;
  assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign w_idle    = r_active && (r_state == S_IDLE);
  assign w_awready = w_idle && !r_aw_full;
  assign w_wready  = w_idle && !r_w_full;
  assign w_aw_hs   = s_axi_awvalid && w_awready;
  assign w_w_hs    = s_axi_wvalid  && w_wready;

  // A write counts as pending for arbitration as soon as both halves are
  // either held or arriving this cycle; it is only launched once both
  // holders are actually full, which keeps AW+W -> bvalid at two edges.
  assign w_wr_pend  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
  assign w_wr_ready = r_aw_full && r_w_full;
  assign w_conflict = s_axi_arvalid && w_wr_pend;

  // Read wins unless a write is competing and the previous contested grant
  // already went to a read.
  assign w_rd_grant = w_idle && s_axi_arvalid && (!w_wr_pend || !r_last_rd);
  assign w_wr_go    = w_idle && w_wr_ready && !w_rd_grant;

  // Valid in the limit cycle takes priority over the timeout.
  assign w_to_hit   = (r_cnt == CNT_LAST) && !reg_readdatavalid;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and strobes / channel outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    reg_read      = 1'b0;
    reg_write     = 1'b0;
    case (r_state)
      S_IDLE: begin
        s_axi_arready = w_rd_grant;
        if (w_rd_grant)   w_next = S_RD;
        else if (w_wr_go) w_next = S_WR;
      end
      S_WR: begin
        reg_write = 1'b1;
        w_next    = S_BRESP;
      end
      S_BRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = S_IDLE;
      end
      S_RD: begin
        reg_read = 1'b1;
        w_next   = S_RWAIT;
      end
      S_RWAIT: begin
        if (reg_readdatavalid || w_to_hit) w_next = S_RRESP;
      end
      S_RRESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Holding registers and arbitration pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      r_active  <= 1'b0;
      r_aw_full <= 1'b0;
      r_awaddr  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_last_rd <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      // Holders are only ever filled in IDLE, so clearing here cannot race.
      if (r_state == S_BRESP && s_axi_bready) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end
      // The pointer only moves when a grant was actually contested.
      if (w_rd_grant && w_conflict)        r_last_rd <= 1'b1;
      else if (w_wr_go && s_axi_arvalid)   r_last_rd <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Register-file side address / data and read return
  // -------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      r_reg_addr  <= '0;
      r_reg_beN   <= 4'hF;
      r_reg_wdata <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
    end else begin
      if (w_rd_grant) begin
        r_reg_addr <= s_axi_araddr[ADDR_WIDTH-1:2];
      end else if (w_wr_go) begin
        r_reg_addr  <= r_awaddr;
        r_reg_beN   <= ~r_wstrb;
        r_reg_wdata <= r_wdata;
      end

      if (r_state == S_RD)         r_cnt <= '0;
      else if (r_state == S_RWAIT) r_cnt <= r_cnt + 1'b1;

      if (r_state == S_RWAIT) begin
        if (reg_readdatavalid) begin
          r_rdata <= reg_readdata;
          r_rresp <= RESP_OKAY;
        end else if (w_to_hit) begin
          r_rdata <= TIMEOUT_DATA;
          r_rresp <= RESP_SLVERR;
        end
      end
    end
  end

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign reg_addr      = r_reg_addr;
  assign reg_beN       = r_reg_beN;
  assign reg_writedata = r_reg_wdata;

endmodule

// File: tb/tb_axi_lite_regfile_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regfile_bridge
//
// Directed sequence plus a randomized phase. A small register-file model
// answers reg_read after a programmable latency and applies reg_write with
// its byte enables; a separate word array updated at AXI level from each
// issued write (wstrb rules) gives the expected read data.
// ---------------------------------------------------------------------------
module tb_axi_lite_regfile_bridge;
  localparam int AW = 11;
  localparam int TO = 64;

  logic          clk, rst_n;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          reg_read, reg_write, reg_readdatavalid;
  logic [AW-3:0] reg_addr;
  logic [3:0]    reg_beN;
  logic [31:0]   reg_writedata, reg_readdata;

  axi_lite_regfile_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO),
                            .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .sysclk(clk), .sysrst_n(rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_beN(reg_beN), .reg_writedata(reg_writedata),
    .reg_readdata(reg_readdata), .reg_readdatavalid(reg_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register-file responder
  logic          auto_rsp, man_vld, rsp_vld;
  logic [31:0]   man_data, rsp_data;
  logic [31:0]   dev [512];
  logic [31:0]   expm [512];
  int            lat, pend_cnt, rd_strobes, wr_strobes;
  logic [AW-3:0] pend_addr, last_wr_addr;
  logic [3:0]    last_wr_ben;
  logic [31:0]   last_wr_data;
  int            ev_q[$];   // 1 = read strobe, 2 = write strobe

  assign reg_readdatavalid = auto_rsp ? rsp_vld  : man_vld;
  assign reg_readdata      = auto_rsp ? rsp_data : man_data;

  initial begin
    rsp_vld = 1'b0; rsp_data = '0; pend_cnt = 0; pend_addr = '0;
    rd_strobes = 0; wr_strobes = 0;
    last_wr_addr = '0; last_wr_ben = '0; last_wr_data = '0;
    for (int i = 0; i < 512; i++) dev[i] = '0;
    forever begin
      @(negedge clk);
      rsp_vld = 1'b0;
      if (!rst_n) pend_cnt = 0;
      else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin rsp_vld = 1'b1; rsp_data = dev[pend_addr]; end
        end
        if (reg_read) begin
          rd_strobes++; ev_q.push_back(1);
          if (auto_rsp) begin pend_addr = reg_addr; pend_cnt = lat; end
        end
        if (reg_write) begin
          wr_strobes++; ev_q.push_back(2);
          last_wr_addr = reg_addr; last_wr_ben = reg_beN; last_wr_data = reg_writedata;
          for (int b = 0; b < 4; b++)
            if (!reg_beN[b]) dev[reg_addr][8*b +: 8] = reg_writedata[8*b +: 8];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] br);
    bit aw_d, w_d; int n;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    aw_d = 0; w_d = 0; n = 0; #1;
    while (!(aw_d && w_d) && n < 50) begin
      if (awvalid && awready) aw_d = 1;
      if (wvalid && wready) w_d = 1;
      tick();
      if (aw_d) awvalid = 1'b0;
      if (w_d) wvalid = 1'b0;
      #1; n++;
    end
    chk("aw_w_accept", 32'(aw_d && w_d), 32'd1);
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    chk("bvalid_wait", 32'(bvalid), 32'd1);
    br = bresp;
    for (int b = 0; b < 4; b++) if (s[b]) expm[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d,
                          output logic [1:0] r);
    int n;
    arvalid = 1'b1; araddr = a; n = 0; #1;
    while (!arready && n < 50) begin tick(); #1; n++; end
    chk("ar_accept", 32'(arready), 32'd1);
    tick(); arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < TO + 50) begin tick(); n++; end
    chk("rvalid_wait", 32'(rvalid), 32'd1);
    d = rdata; r = rresp;
  endtask

  // AW, W and AR offered in the same cycle; each dropped after its handshake.
  task automatic axi_both(input logic [AW-1:0] wa, input logic [31:0] wd,
                          input logic [AW-1:0] ra, output logic [31:0] rd,
                          output logic [1:0] rr);
    bit aw_d, w_d, ar_d, b_got, r_got; int n;
    awvalid = 1'b1; awaddr = wa; wvalid = 1'b1; wdata = wd; wstrb = 4'hF;
    arvalid = 1'b1; araddr = ra;
    aw_d = 0; w_d = 0; ar_d = 0; b_got = 0; r_got = 0; n = 0; rd = 'x; rr = 'x; #1;
    while (!(b_got && r_got) && n < 300) begin
      if (awvalid && awready) aw_d = 1;
      if (wvalid && wready) w_d = 1;
      if (arvalid && arready) ar_d = 1;
      if (bvalid) b_got = 1;
      if (rvalid) begin r_got = 1; rd = rdata; rr = rresp; end
      tick();
      if (aw_d) awvalid = 1'b0;
      if (w_d) wvalid = 1'b0;
      if (ar_d) arvalid = 1'b0;
      #1; n++;
    end
    chk("both_done", 32'({b_got, r_got}), 32'd3);
    expm[wa[AW-1:2]] = wd;
  endtask

  initial begin
    logic [31:0] d, wd;
    logic [1:0]  rr, br;
    logic [AW-1:0] a;
    int s0, cnt, w;
    bit stable;

    rst_n = 1'b0; auto_rsp = 1'b1; man_vld = 1'b0; man_data = '0; lat = 1;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0;
    arvalid = 0; araddr = '0; bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 512; i++) expm[i] = '0;

    // reset values
    tick(); tick();
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_strobes", 32'({reg_read, reg_write}), 0);
    chk("rst_beN", 32'(reg_beN), 32'hF);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wdata", reg_writedata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", 32'({bresp, rresp}), 0);
    rst_n = 1'b1;
    tick(); tick();

    // 1: AW then W three cycles later
    awvalid = 1'b1; awaddr = 11'h010; #1;
    chk("t1_awready", 32'(awready), 1);
    tick(); awvalid = 1'b0;
    tick(); tick();
    wvalid = 1'b1; wdata = 32'hA5A5_5A5A; wstrb = 4'b0011; #1;
    chk("t1_wready", 32'(wready), 1);
    s0 = wr_strobes;
    tick(); wvalid = 1'b0;
    chk("t1_no_early_write", 32'(reg_write), 0);
    chk("t1_no_early_bvalid", 32'(bvalid), 0);
    tick();
    chk("t1_reg_write", 32'(reg_write), 1);
    chk("t1_reg_addr", 32'(reg_addr), 32'h004);
    chk("t1_reg_beN", 32'(reg_beN), 32'b1100);
    chk("t1_wdata", reg_writedata, 32'hA5A5_5A5A);
    tick();
    chk("t1_write_1cyc", 32'(reg_write), 0);
    chk("t1_bvalid", 32'(bvalid), 1);
    chk("t1_bresp", 32'(bresp), 0);
    tick();
    chk("t1_bvalid_drop", 32'(bvalid), 0);
    chk("t1_strobe_count", 32'(wr_strobes - s0), 1);
    expm[4] = 32'h0000_5A5A;

    // 2: AR 0x7FC, readdatavalid 3 cycles after reg_read
    auto_rsp = 1'b0;
    arvalid = 1'b1; araddr = 11'h7FC; #1;
    chk("t2_arready", 32'(arready), 1);
    s0 = rd_strobes;
    tick(); arvalid = 1'b0;
    chk("t2_reg_read", 32'(reg_read), 1);
    chk("t2_reg_addr", 32'(reg_addr), 32'h1FF);
    tick();
    chk("t2_read_1cyc", 32'(reg_read), 0);
    tick(); tick();
    man_vld = 1'b1; man_data = 32'h1234_5678;
    chk("t2_no_early_rvalid", 32'(rvalid), 0);
    tick(); man_vld = 1'b0;
    chk("t2_rvalid", 32'(rvalid), 1);
    chk("t2_rdata", rdata, 32'h1234_5678);
    chk("t2_rresp", 32'(rresp), 0);
    tick();
    chk("t2_rvalid_drop", 32'(rvalid), 0);
    chk("t2_strobe_count", 32'(rd_strobes - s0), 1);

    // 3: no readdatavalid -> timeout after 64 wait cycles
    s0 = rd_strobes;
    arvalid = 1'b1; araddr = 11'h100; #1;
    tick(); arvalid = 1'b0;
    cnt = 0;
    for (int i = 0; i < TO; i++) begin tick(); if (rvalid) cnt++; end
    chk("t3_no_early_rvalid", 32'(cnt), 0);
    tick();
    chk("t3_rvalid", 32'(rvalid), 1);
    chk("t3_rdata", rdata, 32'hDEAD_BEEF);
    chk("t3_rresp", 32'(rresp), 32'h2);
    tick();
    man_vld = 1'b1; man_data = 32'h0BAD_0BAD;
    tick(); man_vld = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (rvalid) cnt++; end
    chk("t3_late_ignored", 32'(cnt), 0);
    chk("t3_strobe_count", 32'(rd_strobes - s0), 1);

    // 3b: valid in the limit cycle wins over the timeout
    arvalid = 1'b1; araddr = 11'h104; #1;
    tick(); arvalid = 1'b0;
    cnt = 0;
    for (int i = 0; i < TO; i++) begin
      tick(); if (rvalid) cnt++;
      if (i == TO - 1) begin man_vld = 1'b1; man_data = 32'hCAFE_0064; end
    end
    tick(); man_vld = 1'b0;
    chk("t3b_no_early_rvalid", 32'(cnt), 0);
    chk("t3b_rvalid", 32'(rvalid), 1);
    chk("t3b_rdata", rdata, 32'hCAFE_0064);
    chk("t3b_rresp", 32'(rresp), 0);
    tick();
    auto_rsp = 1'b1;

    // 4: simultaneous write and read, twice
    ev_q.delete(); lat = 2;
    axi_both(11'h030, 32'h1111_2222, 11'h010, d, rr);
    chk("t4a_events", 32'(ev_q.size()), 2);
    chk("t4a_first_read", 32'(ev_q[0]), 1);
    chk("t4a_then_write", 32'(ev_q[1]), 2);
    chk("t4a_rdata", d, expm[4]);
    tick(); tick();
    ev_q.delete();
    axi_both(11'h034, 32'h3333_4444, 11'h010, d, rr);
    chk("t4b_events", 32'(ev_q.size()), 2);
    chk("t4b_first_write", 32'(ev_q[0]), 2);
    chk("t4b_then_read", 32'(ev_q[1]), 1);
    chk("t4b_rresp", 32'(rresp === 2'b00 && rr === 2'b00), 1);
    tick(); tick();

    // wstrb = 0 still writes, with all byte enables off
    axi_write(11'h022, 32'hFFFF_FFFF, 4'h0, br);
    chk("strb0_beN", 32'(last_wr_ben), 32'hF);
    chk("strb0_addr", 32'(last_wr_addr), 32'h008);
    tick();
    axi_read(11'h020, d, rr);
    chk("strb0_readback", d, expm[8]);
    tick();

    // 5: back-pressure on B and R
    bready = 1'b0;
    axi_write(11'h044, 32'hBEEF_0001, 4'hF, br);
    s0 = rd_strobes + wr_strobes; stable = 1;
    arvalid = 1'b1; araddr = 11'h010;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bvalid || bresp !== 2'b00 || arready) stable = 0;
    end
    chk("t5_b_stable", 32'(stable), 1);
    chk("t5_b_no_strobe", 32'(rd_strobes + wr_strobes - s0), 0);
    arvalid = 1'b0; bready = 1'b1;
    tick();
    chk("t5_b_done", 32'(bvalid), 0);
    rready = 1'b0; lat = 3;
    axi_read(11'h044, d, rr);
    chk("t5_rdata", d, 32'hBEEF_0001);
    s0 = rd_strobes + wr_strobes; stable = 1;
    awvalid = 1'b1; awaddr = 11'h048; wvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rvalid || rdata !== d || rresp !== 2'b00 || awready || wready) stable = 0;
    end
    chk("t5_r_stable", 32'(stable), 1);
    chk("t5_r_no_strobe", 32'(rd_strobes + wr_strobes - s0), 0);
    awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1;
    tick();
    chk("t5_r_done", 32'(rvalid), 0);

    // 6: reset during RWAIT
    auto_rsp = 1'b0;
    arvalid = 1'b1; araddr = 11'h010; #1;
    tick(); arvalid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0; awvalid = 1'b1; wvalid = 1'b1; #1;
    chk("t6_rvalid", 32'(rvalid), 0);
    chk("t6_readies", 32'({awready, wready, arready}), 0);
    chk("t6_strobes", 32'({reg_read, reg_write}), 0);
    chk("t6_beN", 32'(reg_beN), 32'hF);
    chk("t6_addr", 32'(reg_addr), 0);
    chk("t6_rdata", rdata, 0);
    awvalid = 1'b0; wvalid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    s0 = rd_strobes + wr_strobes;
    man_vld = 1'b1; man_data = 32'h7777_7777;
    tick(); man_vld = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (rvalid || bvalid) cnt++; end
    chk("t6_no_response", 32'(cnt), 0);
    chk("t6_no_strobe", 32'(rd_strobes + wr_strobes - s0), 0);
    auto_rsp = 1'b1; lat = 1;
    axi_read(11'h010, d, rr);
    chk("t6_after_rdata", d, expm[4]);
    chk("t6_after_rresp", 32'(rr), 0);
    tick();

    // randomized sequential traffic against the word model
    for (int i = 0; i < 40; i++) begin
      w = int'($urandom_range(0, 15));
      a = {(w < 8) ? 9'(w) : 9'(504 + w - 8), 2'($urandom_range(0, 3))};
      lat = int'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        axi_write(a, wd, 4'($urandom_range(0, 15)), br);
        chk("rnd_bresp", 32'(br), 0);
      end else begin
        axi_read(a, d, rr);
        chk("rnd_rdata", d, expm[a[AW-1:2]]);
        chk("rnd_rresp", 32'(rr), 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
